mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle control FSM for the rv32i core. It drives the ALU_Operation code and the operand, memory and write-back strobes of a multi-cycle datapath. It is the issuing end of the ALU interface: it decides which 4-bit operation the ALU executes and when the result is captured. It sits between the instruction register and the shared ALU/memory datapath.

## Interface
Parameters: none.

- clk  in  1  Core clock; all state changes on rising edge.
- rst  in  1  Asynchronous, active-high reset.
- instr  in  32  Instruction register contents; valid from DECODE onward.
- zero  in  1  ALU ZERO flag (result == 0).
- mem_ready  in  1  Memory completes the current read/write this cycle.
- ALU_Operation  out  4  Operation code: AND 0000, OR 0001, ADD 0010, SUB 0110.
- alu_src_a  out  2  0 = PC, 1 = rs1, 2 = old PC.
- alu_src_b  out  2  0 = rs2, 1 = constant 4, 2 = immediate.
- iord  out  1  Memory address select: 0 = PC, 1 = ALUOut register.
- mem_read  out  1  Memory read request.
- mem_write  out  1  Memory write request.
- ir_write  out  1  Latch instruction and old PC.
- pc_write  out  1  Update PC.
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- reg_write  out  1  Register file write.
- result_src  out  1  Write-back source: 0 = ALUOut, 1 = memory data register.
- illegal  out  1  Sticky unsupported-instruction flag.
- state  out  4  Current state, for debug and bench.

## Operation
- States: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, ADDR 4, MEM_RD 5, MEM_WR 6, WB_ALU 7, WB_MEM 8, BRANCH 9, TRAP 10. Encodings 11–15 go to FETCH on the next edge.
- Outputs are decoded from state, plus instr and zero where noted.
- Outside the listed assertions, every strobe is 0, every select is 0, and ALU_Operation = ADD.
- FETCH:
  - Asserts mem_read=1, iord=0, a=PC, b=4, ADD.
  - While mem_ready=0: stays in FETCH.
  - On mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then goes to DECODE.
- DECODE:
  - Computes the branch target: a=old PC, b=imm, ADD.
  - Next state by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 → ADDR
    - 1100011 with funct3=000 → BRANCH
  - Any other opcode/funct combination → TRAP, including the unsupported funct checks listed for EXEC_R and EXEC_I.
- EXEC_R: a=rs1, b=rs2. Operation by funct3/funct7:
  - 000/0000000 → ADD
  - 000/0100000 → SUB
  - 111/0000000 → AND
  - 110/0000000 → OR
  - Next state WB_ALU.
- EXEC_I: a=rs1, b=imm. Operation by funct3: 000 → ADD, 111 → AND, 110 → OR. Next state WB_ALU.
- ADDR: a=rs1, b=imm, ADD. Next: MEM_RD if opcode is 0000011, otherwise MEM_WR.
- MEM_RD: mem_read=1, iord=1. Holds until mem_ready, then goes to WB_MEM.
- MEM_WR: mem_write=1, iord=1. Holds until mem_ready, then goes to FETCH.
- WB_ALU: reg_write=1, result_src=0, then FETCH.
- WB_MEM: reg_write=1, result_src=1, then FETCH.
- BRANCH: a=rs1, b=rs2, SUB; pc_src=1; pc_write=zero (same cycle). Next state FETCH.
- TRAP: illegal=1, all strobes 0. Stays in TRAP until rst.

## Timing
- Reset:
  - rst=1 forces state=FETCH immediately and illegal=0.
  - While rst=1, all strobes (mem_read, mem_write, ir_write, pc_write, reg_write) are gated to 0.
  - After rst deasserts, FETCH issues on the next cycle.
- Reset mid-operation aborts the current instruction, including a pending memory access. Memory must tolerate the request dropping without mem_ready.
- Latency with mem_ready held at 1:
  - R/I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - Each cycle of mem_ready=0 adds one cycle.
- mem_ready is sampled only in FETCH, MEM_RD and MEM_WR; it is ignored elsewhere.
- Request strobes stay stable and asserted until the mem_ready cycle inclusive.
- Exactly one ir_write pulse per instruction; at most one pc_write in a non-FETCH state.
- The zero flag is used combinationally in BRANCH only.

## Test plan
- add x3,x1,x2 (0x002081B3), mem_ready=1 → states 0,1,2,7; ALU_Operation=0010 in EXEC_R; reg_write=1 in cycle 4 only.
- sub (0x402081B3) then ori (0x0060E193) → ALU_Operation 0110 in EXEC_R, then 0001 in EXEC_I; both reach WB_ALU.
- lw with mem_ready low for 3 cycles in FETCH and 2 in MEM_RD → mem_read held throughout; total 10 cycles; reg_write with result_src=1 exactly once.
- beq with zero=1, then with zero=0 → pc_write=1 with pc_src=1 in BRANCH for the first case; pc_write=0 in BRANCH for the second.
- Opcode 0x7F and R-type funct3=001 → TRAP; illegal=1 and no strobes for 20 cycles; rst clears to FETCH.
- rst asserted mid-MEM_WR → mem_write drops the same cycle; state=0.

Source files
------------

// File: rtl/mc_control_if.sv
// Control-side bundle between the multi-cycle FSM and the rv32i datapath.
interface mc_control_if;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;
   logic [3:0]  ALU_Operation;
   logic [1:0]  alu_src_a;
   logic [1:0]  alu_src_b;
   logic        iord;
   logic        mem_read;
   logic        mem_write;
   logic        ir_write;
   logic        pc_write;
   logic        pc_src;
   logic        reg_write;
   logic        result_src;
   logic        illegal;
   logic [3:0]  state;

   modport master (
      input  instr, zero, mem_ready,
      output ALU_Operation, alu_src_a, alu_src_b,
      output iord, mem_read, mem_write, ir_write,
      output pc_write, pc_src, reg_write, result_src,
      output illegal, state
   );

   modport slave (
      output instr, zero, mem_ready,
      input  ALU_Operation, alu_src_a, alu_src_b,
      input  iord, mem_read, mem_write, ir_write,
      input  pc_write, pc_src, reg_write, result_src,
      input  illegal, state
   );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle rv32i control FSM: sequences fetch/decode/execute/memory/
// write-back and issues the ALU operation and datapath strobes.
module mc_control (
   input  logic         clk,
   input  logic         rst,
   mc_control_if.master bus
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      EXEC_R = 4'd2,
      EXEC_I = 4'd3,
      ADDR   = 4'd4,
      MEM_RD = 4'd5,
      MEM_WR = 4'd6,
      WB_ALU = 4'd7,
      WB_MEM = 4'd8,
      BRANCH = 4'd9,
      TRAP   = 4'd10
   } state_t;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;

   localparam logic [1:0] A_PC    = 2'd0;
   localparam logic [1:0] A_RS1   = 2'd1;
   localparam logic [1:0] A_OLDPC = 2'd2;
   localparam logic [1:0] B_RS2   = 2'd0;
   localparam logic [1:0] B_FOUR  = 2'd1;
   localparam logic [1:0] B_IMM   = 2'd2;

   localparam logic [6:0] OPC_R  = 7'b0110011;
   localparam logic [6:0] OPC_I  = 7'b0010011;
   localparam logic [6:0] OPC_LD = 7'b0000011;
   localparam logic [6:0] OPC_ST = 7'b0100011;
   localparam logic [6:0] OPC_BR = 7'b1100011;

   state_t state_q, state_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_instr;

   assign opcode = bus.instr[6:0];
   assign funct3 = bus.instr[14:12];
   assign funct7 = bus.instr[31:25];
   assign unused_instr = ^{bus.instr[24:15], bus.instr[11:7]};

   logic is_r, is_i, is_ld, is_st, is_br;
   logic r_add, r_sub, r_and, r_or;
   logic i_ok, br_ok;

   always_comb begin
      is_r  = (opcode == OPC_R);
      is_i  = (opcode == OPC_I);
      is_ld = (opcode == OPC_LD);
      is_st = (opcode == OPC_ST);
      is_br = (opcode == OPC_BR);
      r_add = (funct3 == 3'b000) && (funct7 == 7'b0000000);
      r_sub = (funct3 == 3'b000) && (funct7 == 7'b0100000);
      r_and = (funct3 == 3'b111) && (funct7 == 7'b0000000);
      r_or  = (funct3 == 3'b110) && (funct7 == 7'b0000000);
      i_ok  = (funct3 == 3'b000) || (funct3 == 3'b111) ||
              (funct3 == 3'b110);
      br_ok = (funct3 == 3'b000);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH: begin
            if (bus.mem_ready) state_d = DECODE;
         end
         DECODE: begin
            // Unsupported funct encodings trap here, before any execute state
            unique case (1'b1)
               is_r && (r_add || r_sub || r_and || r_or):
                  state_d = EXEC_R;
               is_i && i_ok:
                  state_d = EXEC_I;
               is_ld || is_st:
                  state_d = ADDR;
               is_br && br_ok:
                  state_d = BRANCH;
               default:
                  state_d = TRAP;
            endcase
         end
         EXEC_R: state_d = WB_ALU;
         EXEC_I: state_d = WB_ALU;
         ADDR: begin
            state_d = is_ld ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            if (bus.mem_ready) state_d = WB_MEM;
         end
         MEM_WR: begin
            if (bus.mem_ready) state_d = FETCH;
         end
         WB_ALU: state_d = FETCH;
         WB_MEM: state_d = FETCH;
         BRANCH: state_d = FETCH;
         TRAP:   state_d = TRAP;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   end

   logic [3:0] alu_op;
   logic [1:0] src_a, src_b;
   logic       iord, mem_rd, mem_wr, ir_wr, pc_wr;
   logic       pc_src, reg_wr, res_src, illegal;

   always_comb begin
      alu_op  = OP_ADD;
      src_a   = A_PC;
      src_b   = B_RS2;
      iord    = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      ir_wr   = 1'b0;
      pc_wr   = 1'b0;
      pc_src  = 1'b0;
      reg_wr  = 1'b0;
      res_src = 1'b0;
      illegal = 1'b0;
      case (state_q)
         FETCH: begin
            mem_rd = 1'b1;
            src_b  = B_FOUR;
            ir_wr  = bus.mem_ready;
            pc_wr  = bus.mem_ready;
         end
         DECODE: begin
            src_a = A_OLDPC;
            src_b = B_IMM;
         end
         EXEC_R: begin
            src_a = A_RS1;
            src_b = B_RS2;
            if (r_sub)      alu_op = OP_SUB;
            else if (r_and) alu_op = OP_AND;
            else if (r_or)  alu_op = OP_OR;
         end
         EXEC_I: begin
            src_a = A_RS1;
            src_b = B_IMM;
            if (funct3 == 3'b111)      alu_op = OP_AND;
            else if (funct3 == 3'b110) alu_op = OP_OR;
         end
         ADDR: begin
            src_a = A_RS1;
            src_b = B_IMM;
         end
         MEM_RD: begin
            mem_rd = 1'b1;
            iord   = 1'b1;
         end
         MEM_WR: begin
            mem_wr = 1'b1;
            iord   = 1'b1;
         end
         WB_ALU: reg_wr = 1'b1;
         WB_MEM: begin
            reg_wr  = 1'b1;
            res_src = 1'b1;
         end
         BRANCH: begin
            // beq: SUB sets zero, which directly qualifies the PC update
            src_a  = A_RS1;
            src_b  = B_RS2;
            alu_op = OP_SUB;
            pc_src = 1'b1;
            pc_wr  = bus.zero;
         end
         TRAP: illegal = 1'b1;
         default: ;
      endcase
   end

   assign bus.ALU_Operation = alu_op;
   assign bus.alu_src_a     = src_a;
   assign bus.alu_src_b     = src_b;
   assign bus.iord          = iord;
   assign bus.pc_src        = pc_src;
   assign bus.result_src    = res_src;
   assign bus.illegal       = illegal;
   assign bus.state         = state_q;

   // Strobes are gated while reset is held so aborted accesses drop at once
   assign bus.mem_read  = mem_rd & ~rst;
   assign bus.mem_write = mem_wr & ~rst;
   assign bus.ir_write  = ir_wr  & ~rst;
   assign bus.pc_write  = pc_wr  & ~rst;
   assign bus.reg_write = reg_wr & ~rst;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: a per-instruction trace model plus
// literal latency/strobe expectations.
module tb_mc_control;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mc_control_if bus ();

   mc_control dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [3:0] op;
      logic [1:0] a;
      logic [1:0] b;
      logic       iord, mr, mw, irw, pcw, pcs, rw, rs, ill;
   } out_t;

   typedef struct {
      int   st;
      logic mr;
   } step_t;

   int   checks = 0;
   int   errors = 0;
   int   exp_state = 0;
   logic chk_en = 1'b0;
   int   last_len = 0;
   int   n_regw = 0;
   int   n_rwmem = 0;
   int   n_irw = 0;
   int   n_ill = 0;
   int   n_mw = 0;
   int   last_op = 0;
   int   last_br_pcw = 0;
   out_t o;

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_SUB  = 32'h402081B3;
   localparam logic [31:0] I_ORI  = 32'h0060E193;
   localparam logic [31:0] I_AND  = 32'h0020F1B3;
   localparam logic [31:0] I_ANDI = 32'h0060F193;
   localparam logic [31:0] I_ADDI = 32'h00108093;
   localparam logic [31:0] I_LW   = 32'h0000A183;
   localparam logic [31:0] I_SW   = 32'h0020A023;
   localparam logic [31:0] I_BEQ  = 32'h00208063;
   localparam logic [31:0] I_BAD  = 32'h0000007F;
   localparam logic [31:0] I_SLL  = 32'h002091B3;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t",
                  name, act, req, $time);
      end
   endtask

   // 0 R-type, 1 I-type, 2 load, 3 store, 4 beq, 5 illegal
   function automatic int klass(input logic [31:0] ins);
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      opc = ins[6:0];
      f3  = ins[14:12];
      f7  = ins[31:25];
      if (opc == 7'h33) begin
         if (f7 == 7'h20 && f3 == 3'd0) return 0;
         if (f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6))
            return 0;
         return 5;
      end
      if (opc == 7'h13)
         return (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6) ? 1 : 5;
      if (opc == 7'h03) return 2;
      if (opc == 7'h23) return 3;
      if (opc == 7'h63) return (f3 == 3'd0) ? 4 : 5;
      return 5;
   endfunction

   function automatic logic [3:0] mnem_op(input logic [31:0] ins);
      string m;
      if (ins[14:12] == 3'd7)      m = "and";
      else if (ins[14:12] == 3'd6) m = "or";
      else if (ins[6:0] == 7'h33 && ins[30]) m = "sub";
      else                         m = "add";
      if (m == "and") return 4'b0000;
      if (m == "or")  return 4'b0001;
      if (m == "sub") return 4'b0110;
      return 4'b0010;
   endfunction

   function automatic out_t model(input int st, input logic [31:0] ins,
                                  input logic z, input logic rdy,
                                  input logic r);
      out_t e;
      e = '{op: 4'b0010, a: 2'd0, b: 2'd0, default: 1'b0};
      case (st)
         0: begin e.mr = 1; e.b = 1; e.irw = rdy; e.pcw = rdy; end
         1: begin e.a = 2; e.b = 2; end
         2: begin e.a = 1; e.op = mnem_op(ins); end
         3: begin e.a = 1; e.b = 2; e.op = mnem_op(ins); end
         4: begin e.a = 1; e.b = 2; end
         5: begin e.mr = 1; e.iord = 1; end
         6: begin e.mw = 1; e.iord = 1; end
         7: e.rw = 1;
         8: begin e.rw = 1; e.rs = 1; end
         9: begin e.a = 1; e.op = 4'b0110; e.pcs = 1; e.pcw = z; end
         10: e.ill = 1;
         default: ;
      endcase
      if (r) begin
         e.mr = 0; e.mw = 0; e.irw = 0; e.pcw = 0; e.rw = 0;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      #2;
      if (chk_en) begin
         o = model(exp_state, bus.instr, bus.zero, bus.mem_ready, rst);
         chk("state", int'(bus.state), exp_state);
         chk("alu_op", int'(bus.ALU_Operation), int'(o.op));
         chk("src_a", int'(bus.alu_src_a), int'(o.a));
         chk("src_b", int'(bus.alu_src_b), int'(o.b));
         chk("iord", int'(bus.iord), int'(o.iord));
         chk("mem_read", int'(bus.mem_read), int'(o.mr));
         chk("mem_write", int'(bus.mem_write), int'(o.mw));
         chk("ir_write", int'(bus.ir_write), int'(o.irw));
         chk("pc_write", int'(bus.pc_write), int'(o.pcw));
         chk("pc_src", int'(bus.pc_src), int'(o.pcs));
         chk("reg_write", int'(bus.reg_write), int'(o.rw));
         chk("result_src", int'(bus.result_src), int'(o.rs));
         chk("illegal", int'(bus.illegal), int'(o.ill));
         if (bus.reg_write) n_regw++;
         if (bus.reg_write && bus.result_src) n_rwmem++;
         if (bus.ir_write) n_irw++;
         if (bus.illegal) n_ill++;
         if (bus.mem_write) n_mw++;
         if (bus.state == 4'd2 || bus.state == 4'd3)
            last_op = int'(bus.ALU_Operation);
         if (bus.state == 4'd9) last_br_pcw = int'(bus.pc_write);
      end
   end

   task automatic run(input logic [31:0] ins, input int fw, input int mw,
                      input logic z, input logic ign, input int max_len);
      step_t q[$];
      step_t s;
      for (int i = 0; i < fw; i++) q.push_back('{0, 1'b0});
      q.push_back('{0, 1'b1});
      q.push_back('{1, ign});
      case (klass(ins))
         0: begin q.push_back('{2, ign}); q.push_back('{7, ign}); end
         1: begin q.push_back('{3, ign}); q.push_back('{7, ign}); end
         2: begin
            q.push_back('{4, ign});
            for (int i = 0; i < mw; i++) q.push_back('{5, 1'b0});
            q.push_back('{5, 1'b1});
            q.push_back('{8, ign});
         end
         3: begin
            q.push_back('{4, ign});
            for (int i = 0; i < mw; i++) q.push_back('{6, 1'b0});
            q.push_back('{6, 1'b1});
         end
         4: q.push_back('{9, ign});
         default: for (int i = 0; i < 20; i++) q.push_back('{10, ign});
      endcase
      while (max_len > 0 && q.size() > max_len) s = q.pop_back();
      last_len = q.size();
      foreach (q[i]) begin
         @(negedge clk);
         rst           = 1'b0;
         bus.instr     = ins;
         bus.zero      = z;
         bus.mem_ready = q[i].mr;
         exp_state     = q[i].st;
         chk_en        = 1'b1;
      end
      #3;
   endtask

   task automatic reset_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst       = 1'b1;
         exp_state = 0;
         chk_en    = 1'b1;
      end
      #3;
   endtask

   int r0, m0, i0, l0, w0;

   initial begin
      rst           = 1'b1;
      bus.instr     = '0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;
      reset_cycles(2);
      chk("rst_state", int'(bus.state), 0);
      chk("rst_illegal", int'(bus.illegal), 0);

      r0 = n_regw;
      run(I_ADD, 0, 0, 1'b0, 1'b1, 0);
      chk("add_len", last_len, 4);
      chk("add_op", last_op, 2);
      chk("add_regw", n_regw - r0, 1);

      run(I_SUB, 0, 0, 1'b0, 1'b0, 0);
      chk("sub_op", last_op, 6);
      run(I_ORI, 0, 0, 1'b1, 1'b0, 0);
      chk("ori_op", last_op, 1);
      chk("ori_len", last_len, 4);
      run(I_AND, 0, 0, 1'b0, 1'b1, 0);
      chk("and_op", last_op, 0);
      run(I_ANDI, 1, 0, 1'b0, 1'b0, 0);
      chk("andi_op", last_op, 0);
      run(I_ADDI, 0, 0, 1'b0, 1'b1, 0);
      chk("addi_op", last_op, 2);

      r0 = n_regw; m0 = n_rwmem; i0 = n_irw;
      run(I_LW, 3, 2, 1'b0, 1'b0, 0);
      chk("lw_wait_len", last_len, 10);
      chk("lw_regw", n_regw - r0, 1);
      chk("lw_regw_mem", n_rwmem - m0, 1);
      chk("lw_irw", n_irw - i0, 1);

      r0 = n_regw; w0 = n_mw;
      run(I_SW, 0, 0, 1'b0, 1'b1, 0);
      chk("sw_len", last_len, 4);
      chk("sw_regw", n_regw - r0, 0);
      chk("sw_memw", n_mw - w0, 1);

      run(I_LW, 0, 0, 1'b1, 1'b1, 0);
      chk("lw_len", last_len, 5);

      run(I_BEQ, 0, 0, 1'b1, 1'b1, 0);
      chk("beq_len", last_len, 3);
      chk("beq_taken_pcw", last_br_pcw, 1);
      run(I_BEQ, 0, 0, 1'b0, 1'b0, 0);
      chk("beq_nt_pcw", last_br_pcw, 0);

      l0 = n_ill;
      run(I_BAD, 0, 0, 1'b0, 1'b1, 0);
      chk("bad_illegal_cycles", n_ill - l0, 20);
      reset_cycles(2);
      chk("bad_rst_state", int'(bus.state), 0);
      chk("bad_rst_illegal", int'(bus.illegal), 0);

      l0 = n_ill;
      run(I_SLL, 0, 0, 1'b1, 1'b0, 0);
      chk("sll_illegal_cycles", n_ill - l0, 20);
      reset_cycles(1);
      run(I_ADDI, 0, 0, 1'b0, 1'b1, 0);
      chk("recover_len", last_len, 4);

      run(I_SW, 0, 3, 1'b0, 1'b1, 4);
      chk("abort_mw_before", int'(bus.mem_write), 1);
      reset_cycles(2);
      chk("abort_state", int'(bus.state), 0);
      chk("abort_mw", int'(bus.mem_write), 0);

      run(I_ADD, 1, 0, 1'b0, 1'b0, 0);
      chk("final_len", last_len, 5);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
